tempo_controller: RTL and testbench
===================================

Name: tempo_controller

Overview:
Parametrised playback-tempo generator for the player. Converts debounced speed-up and speed-down button levels into a saturating tempo level with edge detection, hold-to-repeat and direct load. From that level it produces a registered 50% duty play clock and a one-cycle play tick. One clock domain throughout, with no clock muxing. It sits between the button debounce stage and the note/sequence player, which consumes play_tick as its enable.

Parameters:
LEVELS, 4, number of tempo levels (>=2); level 0 = slowest, LEVELS-1 = fastest.
FAST_LOG2, 22, log2 of the play period in clk cycles at the fastest level (>=1).
DEFAULT_LEVEL, 1, level loaded at reset (< LEVELS).
REPEAT_DELAY, 25000000, cycles a button must be held after its press step before auto-repeat starts; 0 disables auto-repeat.
REPEAT_RATE, 12500000, cycles between auto-repeat steps (>=1).
LW, $clog2(LEVELS), width of the level ports (derived).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
speedup  in  1  debounced level, high while the button is held
speeddown  in  1  debounced level, high while the button is held
set_en  in  1  one-cycle load strobe
set_level  in  LW  level to load when set_en is high
pause  in  1  freezes the tempo phase
level  out  LW  current tempo level
at_min  out  1  level == 0
at_max  out  1  level == LEVELS-1
level_changed  out  1  one-cycle pulse in the cycle after level changes
play_clk  out  1  registered square wave, period P(level)
play_tick  out  1  one-cycle pulse coincident with each play_clk rising edge

Behaviour:
- Reset (rst low, async): level=DEFAULT_LEVEL, phase counter=0, play_clk=0, play_tick=0, level_changed=0, both repeat FSMs in IDLE, button history registers=0.
- Period: P(k) = 2^(FAST_LOG2 + LEVELS-1-k); half period H(k) = P(k)/2. Phase counter width is FAST_LOG2+LEVELS-1.
- Phase operation, when pause is low:
  - Counter increments each cycle.
  - When counter == H(level)-1: counter <= 0, play_clk <= ~play_clk, and play_tick <= 1 if play_clk was 0.
  - In all other cycles, play_tick <= 0.
  - First tick after reset release occurs H cycles after release, then every P cycles.
- Pause high: counter, play_clk and play_tick=0 are held. Level changes are still accepted while paused.
- Repeat FSM, one per button, states IDLE / DELAY / REPEAT:
  - Button history is registered. A 0->1 transition emits a step and moves the FSM to DELAY with hold_cnt=0.
  - DELAY: when hold_cnt == REPEAT_DELAY-1, emit a step and go to REPEAT with hold_cnt=0.
  - REPEAT: emit a step every REPEAT_RATE cycles.
  - Button low in any state returns the FSM to IDLE.
  - REPEAT_DELAY=0: the FSM never leaves DELAY (press step only).
- Level update priority, all registered:
  - set_en loads min(set_level, LEVELS-1); this overrides all steps.
  - Else, up step and down step in the same cycle cancel (no change).
  - Else, an up step gives level+1, saturating at LEVELS-1.
  - Else, a down step gives level-1, saturating at 0.
  - A saturated step is not a change.
- On any actual level change: phase counter <= 0, play_clk <= 0, play_tick <= 0, level_changed <= 1 for one cycle. The next tick occurs H(new) cycles later (pause low). A load of the current value is not a change.
- at_min and at_max are combinational from level.
- Reset asserted mid-operation aborts everything immediately; no tick is emitted on release.

Test Plan:
Bench parameters: LEVELS=4, FAST_LOG2=3, DEFAULT_LEVEL=1, REPEAT_DELAY=20, REPEAT_RATE=10. Periods for levels 0..3: 64/32/16/8.
1. Release reset, no input -> level=1; play_tick at cycles 16, 48, 80; play_clk high for 16 cycles, low for 16.
2. One-cycle speedup pulses x3 -> level goes 2, 3, 3; at_max=1; level_changed pulses twice only; tick spacing becomes 8.
3. Hold speeddown 55 cycles from level 3 -> steps at press, +20 and +30 -> level 0, at_min=1; the step due at +40 is suppressed by saturation.
4. speedup and speeddown rising in the same cycle at level 1 -> level stays 1, no level_changed; same cycle with set_en=1, set_level=7 -> level=3.
5. pause high for 100 cycles mid-phase -> play_clk frozen, no ticks; phase resumes from the held count; a speedup during the pause updates level and restarts the phase from 0.
6. rst low while speedup is held and the FSM is in REPEAT -> all outputs return to reset values asynchronously; the held button after release counts as a fresh press only if it goes low then high.

Source files
------------

// File: rtl/tempo_controller.sv
// tempo_controller
// Playback-tempo generator: turns debounced speed-up / speed-down button
// levels into a saturating tempo level (press step, hold-to-repeat, direct
// load). From that level it derives a registered 50% duty play clock and a
// one-cycle play tick that the note/sequence player uses as its enable.
// Single clock domain; play_clk is a plain register output, never a clock.
module tempo_controller #(
    parameter int LEVELS        = 4,
    parameter int FAST_LOG2     = 22,
    parameter int DEFAULT_LEVEL = 1,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_RATE   = 12500000,
    parameter int LW            = $clog2(LEVELS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          speedup,
    input  logic          speeddown,
    input  logic          set_en,
    input  logic [LW-1:0] set_level,
    input  logic          pause,
    output logic [LW-1:0] level,
    output logic          at_min,
    output logic          at_max,
    output logic          level_changed,
    output logic          play_clk,
    output logic          play_tick
);

    // Phase counter must hold H(0)-1, the longest half period.
    localparam int CW       = FAST_LOG2 + LEVELS - 1;
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int HW       = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX);

    localparam logic [LW-1:0] LVL_MAX    = LW'(LEVELS - 1);
    localparam logic [LW-1:0] LVL_DEF    = LW'(DEFAULT_LEVEL);
    localparam logic [HW-1:0] DELAY_LAST = HW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [HW-1:0] RATE_LAST  = HW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rep_state_t;

    // Level +1, held at the top level.
    function automatic logic [LW-1:0] sat_inc(input logic [LW-1:0] l);
        return (l == LVL_MAX) ? l : l + LW'(1);
    endfunction

    // Level -1, held at level 0.
    function automatic logic [LW-1:0] sat_dec(input logic [LW-1:0] l);
        return (l == '0) ? l : l - LW'(1);
    endfunction

    // Direct loads beyond the top level clamp to the top level.
    function automatic logic [LW-1:0] clamp_level(input logic [LW-1:0] l);
        return (l > LVL_MAX) ? LVL_MAX : l;
    endfunction

    // Terminal phase count for a level: H(k)-1 = 2^(CW-1-k) - 1.
    function automatic logic [CW-1:0] half_last(input logic [LW-1:0] l);
        return (CW'(1) << (CW - 1 - int'(l))) - CW'(1);
    endfunction

    logic [1:0]    btn;
    logic [1:0]    step;
    logic [LW-1:0] level_nxt;
    logic          lvl_change;
    logic [CW-1:0] phase_cnt;

    // Bit 0 = speed-up, bit 1 = speed-down.
    assign btn = {speeddown, speedup};

    for (genvar b = 0; b < 2; b++) begin : g_rep
        rep_state_t    state;
        logic          hist;
        logic          armed;
        logic          stp;
        logic [HW-1:0] hold;

        assign step[b] = stp;

        // Repeat FSM: step on press, again after the hold delay, then at the repeat rate.
        // 'armed' stays low after reset until the button is seen low, so a
        // button held through reset is not mistaken for a fresh press.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state <= IDLE;
                hist  <= 1'b0;
                armed <= 1'b0;
                stp   <= 1'b0;
                hold  <= '0;
            end else begin
                hist <= btn[b];
                stp  <= 1'b0;
                if (!btn[b]) begin
                    armed <= 1'b1;
                    state <= IDLE;
                    hold  <= '0;
                end else begin
                    case (state)
                        IDLE: begin
                            if (!hist && armed) begin
                                stp   <= 1'b1;
                                state <= DELAY;
                                hold  <= '0;
                            end
                        end
                        DELAY: begin
                            // With no repeat delay configured the press step is the only step.
                            if (REPEAT_DELAY > 0) begin
                                if (hold == DELAY_LAST) begin
                                    stp   <= 1'b1;
                                    state <= REPEAT;
                                    hold  <= '0;
                                end else begin
                                    hold <= hold + HW'(1);
                                end
                            end
                        end
                        REPEAT: begin
                            if (hold == RATE_LAST) begin
                                stp  <= 1'b1;
                                hold <= '0;
                            end else begin
                                hold <= hold + HW'(1);
                            end
                        end
                        default: begin
                            state <= IDLE;
                            hold  <= '0;
                        end
                    endcase
                end
            end
        end
    end

    // Next level: load beats steps, opposing steps cancel, single steps saturate.
    always_comb begin
        level_nxt = level;
        if (set_en) begin
            level_nxt = clamp_level(set_level);
        end else if (step[0] && step[1]) begin
            level_nxt = level;
        end else if (step[0]) begin
            level_nxt = sat_inc(level);
        end else if (step[1]) begin
            level_nxt = sat_dec(level);
        end
    end

    // Saturated steps and reloads of the current value are not changes.
    assign lvl_change = (level_nxt != level);

    // Level register and its one-cycle change flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level         <= LVL_DEF;
            level_changed <= 1'b0;
        end else begin
            level         <= level_nxt;
            level_changed <= lvl_change;
        end
    end

    // Phase generator: toggle play_clk every half period, tick on its rising edge.
    // A level change restarts the phase even while paused.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_cnt <= '0;
            play_clk  <= 1'b0;
            play_tick <= 1'b0;
        end else if (lvl_change) begin
            phase_cnt <= '0;
            play_clk  <= 1'b0;
            play_tick <= 1'b0;
        end else if (pause) begin
            play_tick <= 1'b0;
        end else if (phase_cnt == half_last(level)) begin
            phase_cnt <= '0;
            play_clk  <= ~play_clk;
            play_tick <= ~play_clk;
        end else begin
            phase_cnt <= phase_cnt + CW'(1);
            play_tick <= 1'b0;
        end
    end

    assign at_min = (level == '0);
    assign at_max = (level == LVL_MAX);

endmodule

// File: tb/tb_tempo_controller.sv
// tb_tempo_controller
// Directed bench for tempo_controller with LEVELS=4, FAST_LOG2=3,
// DEFAULT_LEVEL=1, REPEAT_DELAY=20, REPEAT_RATE=10 (periods 64/32/16/8).
// Inputs change and outputs are sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_tempo_controller;

    localparam int LEVELS        = 4;
    localparam int FAST_LOG2     = 3;
    localparam int DEFAULT_LEVEL = 1;
    localparam int REPEAT_DELAY  = 20;
    localparam int REPEAT_RATE   = 10;
    localparam int LW            = 2;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          speedup   = 1'b0;
    logic          speeddown = 1'b0;
    logic          set_en    = 1'b0;
    logic [LW-1:0] set_level = '0;
    logic          pause     = 1'b0;
    logic [LW-1:0] level;
    logic          at_min;
    logic          at_max;
    logic          level_changed;
    logic          play_clk;
    logic          play_tick;

    int checks   = 0;
    int errors   = 0;
    int chg_seen = 0;

    always #5 clk = ~clk;

    tempo_controller #(
        .LEVELS       (LEVELS),
        .FAST_LOG2    (FAST_LOG2),
        .DEFAULT_LEVEL(DEFAULT_LEVEL),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE),
        .LW           (LW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .speedup      (speedup),
        .speeddown    (speeddown),
        .set_en       (set_en),
        .set_level    (set_level),
        .pause        (pause),
        .level        (level),
        .at_min       (at_min),
        .at_max       (at_max),
        .level_changed(level_changed),
        .play_clk     (play_clk),
        .play_tick    (play_tick)
    );

    // Advance to the next falling edge and tally level_changed pulses.
    task automatic cycle();
        @(negedge clk);
        chg_seen += int'(level_changed);
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (level !== 2'd1 || play_clk !== 1'b0 || play_tick !== 1'b0 || level_changed !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: level=%0d clk=%b tick=%b chg=%b, required level=1 clk=0 tick=0 chg=0",
                     level, play_clk, play_tick, level_changed);
        end
        checks++;
        if (at_min !== 1'b0 || at_max !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: at_min=%b at_max=%b, required 0 0", at_min, at_max);
        end
    endtask

    task automatic test_free_run();
        logic exp_tick, exp_clk;
        rst = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            cycle();
            exp_tick = ((k % 32) == 16);
            exp_clk  = (((k / 16) % 2) == 1);
            checks++;
            if (play_tick !== exp_tick || play_clk !== exp_clk || level !== 2'd1) begin
                errors++;
                $display("FAIL free_run cycle %0d: tick=%b clk=%b level=%0d, required tick=%b clk=%b level=1",
                         k, play_tick, play_clk, level, exp_tick, exp_clk);
            end
        end
    endtask

    task automatic test_speedup_pulses();
        logic [LW-1:0] exp_lvl;
        logic          exp_chg;
        logic          found;
        int            gap;
        chg_seen = 0;
        for (int p = 0; p < 3; p++) begin
            speedup = 1'b1;
            cycle();
            speedup = 1'b0;
            cycle();
            exp_lvl = (p == 0) ? 2'd2 : 2'd3;
            exp_chg = (p < 2);
            checks++;
            if (level !== exp_lvl || level_changed !== exp_chg) begin
                errors++;
                $display("FAIL speedup_pulse %0d: level=%0d chg=%b, required level=%0d chg=%b",
                         p, level, level_changed, exp_lvl, exp_chg);
            end
            repeat (3) cycle();
        end
        checks++;
        if (at_max !== 1'b1 || at_min !== 1'b0) begin
            errors++;
            $display("FAIL speedup_at_max: at_max=%b at_min=%b, required 1 0", at_max, at_min);
        end
        checks++;
        if (chg_seen != 2) begin
            errors++;
            $display("FAIL speedup_change_count: %0d pulses, required 2", chg_seen);
        end
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            cycle();
            if (play_tick === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL fast_tick_found: no tick within 20 cycles, required a tick");
        end
        for (int r = 0; r < 2; r++) begin
            gap = 0;
            do begin
                cycle();
                gap++;
            end while (play_tick !== 1'b1 && gap < 20);
            checks++;
            if (gap != 8) begin
                errors++;
                $display("FAIL fast_tick_spacing %0d: gap=%0d, required 8", r, gap);
            end
        end
    endtask

    task automatic test_hold_down();
        logic [LW-1:0] exp_lvl;
        chg_seen  = 0;
        speeddown = 1'b1;
        for (int k = 0; k < 55; k++) begin
            cycle();
            if (k < 1)       exp_lvl = 2'd3;
            else if (k < 21) exp_lvl = 2'd2;
            else if (k < 31) exp_lvl = 2'd1;
            else             exp_lvl = 2'd0;
            if (k == 0 || k == 1 || k == 20 || k == 21 || k == 30 || k == 31 || k == 41 || k == 54) begin
                checks++;
                if (level !== exp_lvl) begin
                    errors++;
                    $display("FAIL hold_down cycle %0d: level=%0d, required %0d", k, level, exp_lvl);
                end
            end
        end
        speeddown = 1'b0;
        cycle();
        checks++;
        if (chg_seen != 3) begin
            errors++;
            $display("FAIL hold_down_change_count: %0d pulses, required 3", chg_seen);
        end
        checks++;
        if (at_min !== 1'b1 || at_max !== 1'b0) begin
            errors++;
            $display("FAIL hold_down_at_min: at_min=%b at_max=%b, required 1 0", at_min, at_max);
        end
    endtask

    task automatic test_simultaneous();
        set_en    = 1'b1;
        set_level = 2'd1;
        cycle();
        set_en = 1'b0;
        checks++;
        if (level !== 2'd1 || level_changed !== 1'b1) begin
            errors++;
            $display("FAIL load_level1: level=%0d chg=%b, required 1 1", level, level_changed);
        end
        cycle();
        chg_seen  = 0;
        speedup   = 1'b1;
        speeddown = 1'b1;
        cycle();
        speedup   = 1'b0;
        speeddown = 1'b0;
        cycle();
        cycle();
        checks++;
        if (level !== 2'd1 || chg_seen != 0) begin
            errors++;
            $display("FAIL opposing_steps: level=%0d changes=%0d, required level=1 changes=0", level, chg_seen);
        end
        // Both buttons pressed again; the load lands in the same cycle as both steps.
        speedup   = 1'b1;
        speeddown = 1'b1;
        cycle();
        set_en    = 1'b1;
        set_level = 2'b11;  // requested 7, only the low two bits reach the port
        speedup   = 1'b0;
        speeddown = 1'b0;
        cycle();
        set_en = 1'b0;
        checks++;
        if (level !== 2'd3 || level_changed !== 1'b1) begin
            errors++;
            $display("FAIL load_over_steps: level=%0d chg=%b, required 3 1", level, level_changed);
        end
        set_en    = 1'b1;
        set_level = 2'd3;
        cycle();
        set_en = 1'b0;
        checks++;
        if (level !== 2'd3 || level_changed !== 1'b0) begin
            errors++;
            $display("FAIL load_same_value: level=%0d chg=%b, required 3 0", level, level_changed);
        end
    endtask

    task automatic test_pause();
        int ticks;
        int clk_bad;
        set_en    = 1'b1;
        set_level = 2'd1;
        cycle();
        set_en = 1'b0;
        checks++;
        if (level !== 2'd1) begin
            errors++;
            $display("FAIL pause_setup_level: level=%0d, required 1", level);
        end
        repeat (5) cycle();
        pause   = 1'b1;
        ticks   = 0;
        clk_bad = 0;
        for (int k = 0; k < 100; k++) begin
            cycle();
            ticks += int'(play_tick);
            if (play_clk !== 1'b0) clk_bad++;
        end
        checks++;
        if (ticks != 0 || clk_bad != 0) begin
            errors++;
            $display("FAIL pause_freeze: ticks=%0d clk_high_cycles=%0d, required 0 0", ticks, clk_bad);
        end
        pause = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            cycle();
            checks++;
            if (play_tick !== (k == 11) || play_clk !== (k == 11)) begin
                errors++;
                $display("FAIL pause_resume cycle %0d: tick=%b clk=%b, required tick=%b clk=%b",
                         k, play_tick, play_clk, (k == 11), (k == 11));
            end
        end
        repeat (3) cycle();
        pause = 1'b1;
        repeat (5) cycle();
        checks++;
        if (play_clk !== 1'b1 || play_tick !== 1'b0) begin
            errors++;
            $display("FAIL pause_hold_high: clk=%b tick=%b, required 1 0", play_clk, play_tick);
        end
        speedup = 1'b1;
        cycle();
        speedup = 1'b0;
        cycle();
        checks++;
        if (level !== 2'd2 || level_changed !== 1'b1 || play_clk !== 1'b0) begin
            errors++;
            $display("FAIL pause_speedup: level=%0d chg=%b clk=%b, required 2 1 0", level, level_changed, play_clk);
        end
        ticks   = 0;
        clk_bad = 0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            ticks += int'(play_tick);
            if (play_clk !== 1'b0) clk_bad++;
        end
        checks++;
        if (ticks != 0 || clk_bad != 0) begin
            errors++;
            $display("FAIL pause_after_change: ticks=%0d clk_high_cycles=%0d, required 0 0", ticks, clk_bad);
        end
        pause = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cycle();
            checks++;
            if (play_tick !== (k == 8)) begin
                errors++;
                $display("FAIL restart_phase cycle %0d: tick=%b, required %b", k, play_tick, (k == 8));
            end
        end
    endtask

    task automatic test_reset_in_repeat();
        speedup = 1'b1;
        repeat (25) cycle();
        checks++;
        if (level !== 2'd3) begin
            errors++;
            $display("FAIL repeat_setup_level: level=%0d, required 3", level);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (level !== 2'd1 || play_clk !== 1'b0 || play_tick !== 1'b0 || level_changed !== 1'b0 || at_max !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: level=%0d clk=%b tick=%b chg=%b at_max=%b, required 1 0 0 0 0",
                     level, play_clk, play_tick, level_changed, at_max);
        end
        repeat (3) @(negedge clk);
        rst      = 1'b1;
        chg_seen = 0;
        for (int k = 1; k <= 30; k++) begin
            cycle();
            checks++;
            if (level !== 2'd1 || play_tick !== (k == 16)) begin
                errors++;
                $display("FAIL held_through_reset cycle %0d: level=%0d tick=%b, required level=1 tick=%b",
                         k, level, play_tick, (k == 16));
            end
        end
        checks++;
        if (chg_seen != 0) begin
            errors++;
            $display("FAIL held_through_reset_changes: %0d pulses, required 0", chg_seen);
        end
        speedup = 1'b0;
        cycle();
        cycle();
        speedup = 1'b1;
        cycle();
        speedup = 1'b0;
        cycle();
        checks++;
        if (level !== 2'd2 || level_changed !== 1'b1) begin
            errors++;
            $display("FAIL fresh_press_after_reset: level=%0d chg=%b, required 2 1", level, level_changed);
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_speedup_pulses();
        test_hold_down();
        test_simultaneous();
        test_pause();
        test_reset_in_repeat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
